// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the two-port memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam logic [3:0] WMASK_NONE = 4'hf;

  // Wide enough for MEM_LATENCY-1 with MEM_LATENCY up to 7.
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Combinational 2-way round-robin pick; the port not granted last wins a tie.
module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = PORT_CPU;
    if (req == 2'b11) begin
      grant_id = ~last_grant;
    end else if (req[1]) begin
      grant_id = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises complete memory_bus transactions from two masters (CPU, DMA)
// with req/ack handshakes, round-robin priority and registered outputs.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [3:0]            p0_wmask,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic [3:0]            p1_wmask,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write,
  output logic [3:0]            mem_write_mask,
  output logic                  mem_bus_enable,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read,
  output logic                  grant_id,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  prio_q;
  logic                  grant_q;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            mask_q;
  logic                  ben_q;
  logic                  wen_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;

  logic                  pick_valid;
  logic                  pick_id;
  logic                  last_grant;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [3:0]            sel_wmask;

  // prio_q names the preferred port, so the arbiter sees the other one as last.
  assign last_grant = ~prio_q;

  rr_arbiter2 u_rr (
    .req         ({p1_req, p0_req}),
    .last_grant  (last_grant),
    .grant_valid (pick_valid),
    .grant_id    (pick_id)
  );

  always_comb begin
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    sel_wmask = p0_wmask;
    if (pick_id == PORT_DMA) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
      sel_wmask = p1_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      cnt_q    <= '0;
      prio_q   <= PORT_CPU;
      grant_q  <= PORT_CPU;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= WMASK_NONE;
      ben_q    <= 1'b0;
      wen_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            mask_q  <= sel_we ? sel_wmask : WMASK_NONE;
            ben_q   <= 1'b1;
            wen_q   <= sel_we;
            grant_q <= pick_id;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_LOAD;
            state_q <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (cnt_q == '0) begin
            if (grant_q == PORT_DMA) begin
              rdata1_q <= mem_read;
              ack1_q   <= 1'b1;
            end else begin
              rdata0_q <= mem_read;
              ack0_q   <= 1'b1;
            end
            ben_q   <= 1'b0;
            wen_q   <= 1'b0;
            prio_q  <= ~grant_q;
            state_q <= ARB_ACK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ARB_ACK: begin
          // Requests are ignored here so a master still holding req is not re-granted.
          busy_q  <= 1'b0;
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign p0_ack           = ack0_q;
  assign p1_ack           = ack1_q;
  assign p0_rdata         = rdata0_q;
  assign p1_rdata         = rdata1_q;
  assign mem_address      = addr_q;
  assign mem_write        = wdata_q;
  assign mem_write_mask   = mask_q;
  assign mem_bus_enable   = ben_q;
  assign mem_write_enable = wen_q;
  assign grant_id         = grant_q;
  assign busy             = busy_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-port arbiter that shares the single memory_bus port (ROM/RAM/peripherals) between the CPU core (port 0) and a secondary master such as a DMA/SPI program loader (port 1). It serialises complete bus transactions with a per-port req/ack handshake and applies round-robin priority. It owns the bus_enable and write_enable sequencing, so neither master drives memory_bus directly.

Parameters:
ADDR_WIDTH, 16, address width of memory_bus.
DATA_WIDTH, 32, data width of memory_bus.
MEM_LATENCY, 1, cycles from bus_enable assertion to valid data_out; legal range 1..7.

Ports:
clk  input  1  system clock (CPU divided clock); all logic on rising edge.
reset  input  1  synchronous, active-high reset.
p0_req  input  1  port 0 (CPU) request; held high with the command fields stable until p0_ack.
p0_we  input  1  port 0: 1 = write, 0 = read.
p0_addr  input  ADDR_WIDTH  port 0 byte address.
p0_wdata  input  DATA_WIDTH  port 0 write data.
p0_wmask  input  4  port 0 byte-lane mask, active-low (0 = write that lane).
p0_ack  output  1  one-cycle pulse; the transaction is complete and p0_rdata is valid.
p0_rdata  output  DATA_WIDTH  port 0 read data, held until the next port 0 ack.
p1_req / p1_we / p1_addr / p1_wdata / p1_wmask / p1_ack / p1_rdata  same widths and meanings for port 1.
mem_address  output  ADDR_WIDTH  to memory_bus address.
mem_write  output  DATA_WIDTH  to memory_bus data_in.
mem_write_mask  output  4  to memory_bus write_mask.
mem_bus_enable  output  1  to memory_bus bus_enable.
mem_write_enable  output  1  to memory_bus write_enable.
mem_read  input  DATA_WIDTH  from memory_bus data_out.
grant_id  output  1  port owning the current or last transaction.
busy  output  1  high in BUSY and ACK states.

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs 0. mem_write_mask = 4'hf. Priority pointer = port 0.
- Reset during a transaction aborts it: no ack is issued, and the bus is released on the following cycle.
- States: IDLE, BUSY, ACK. All outputs are registered.
- IDLE, no request: stay in IDLE; mem_bus_enable = 0, mem_write_enable = 0.
- IDLE, one req high: grant that port.
- IDLE, both req high: grant the port that was not granted last (round-robin).
- On grant (edge at the end of cycle N):
  - latch the winner's addr, wdata, wmask and we onto the mem_* outputs;
  - mem_bus_enable <= 1; mem_write_enable <= we;
  - for reads, mem_write_mask is forced to 4'hf;
  - grant_id <= winner; load the latency counter with MEM_LATENCY-1; go to BUSY.
- BUSY: command outputs are held stable. Each cycle the counter decrements. When counter = 0:
  - rdata of the granted port <= mem_read (loaded for writes too; content is don't-care);
  - that port's ack <= 1;
  - mem_bus_enable <= 0; mem_write_enable <= 0;
  - flip the priority pointer to the other port; go to ACK.
- ACK: ack is high for exactly this one cycle. All req inputs are ignored, which guards against re-arbitrating a request the master has not yet dropped. Go to IDLE.
- Latency, request-to-ack with req sampled in cycle N: bus_enable visible N+1..N+MEM_LATENCY, ack visible at N+MEM_LATENCY+1. Minimum transaction period = MEM_LATENCY+2 cycles.
- Back-to-back: a req that is still high in the cycle after ACK is treated as a new transaction. Masters deassert req in their ack cycle.
- Starvation: with both ports continuously requesting, grants strictly alternate 0,1,0,1.
- A req dropped before ack is a protocol violation. The transaction still completes and ack still pulses.
- The command fields of a non-granted port have no effect on mem_*.
- Only one ack can be high in any cycle.

Decomposition:
- Shared package / include: state encodings (ARB_IDLE = 0, ARB_BUSY = 1, ARB_ACK = 2), port IDs (PORT_CPU = 0, PORT_DMA = 1), WMASK_NONE = 4'hf.
- Sub-module rr_arbiter2: combinational 2-way round-robin pick.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant_valid, grant_id.
- FSM, latency counter and output registers stay in mem_bus_arbiter.

Test Plan:
- Single read: MEM_LATENCY=1, mem_read = 32'hdeadbeef, p0 read of 16'h4000 sampled in cycle 0 -> mem_bus_enable = 1 in cycle 1 only, mem_address = 16'h4000, p0_ack in cycle 2, p0_rdata = 32'hdeadbeef, p1_ack never asserts.
- Byte write: p1 write of 16'h8002 with wdata 32'h55555555 and wmask 4'b1011 -> mem_write_enable = mem_bus_enable = 1 in cycle 1, mem_write_mask = 4'b1011, grant_id = 1, p1_ack in cycle 2.
- Contention: p0 and p1 assert req together from reset and hold it until ack, then re-raise next cycle -> grant order 0,1,0,1 and an ack every 3 cycles.
- Latency parameter: MEM_LATENCY=3 -> mem_bus_enable high for 3 cycles, ack 4 cycles after the request; mem_read changed mid-window is ignored and only the last-cycle value is captured.
- Held req: p0 keeps req high through the ack cycle -> no grant in the ACK cycle, second transaction issued in the following cycle.
- Reset mid-op: reset asserted in cycle 1 of a MEM_LATENCY=3 read -> next cycle all outputs 0, mem_write_mask = 4'hf, no ack; after release, p1 and p0 both requesting -> port 0 granted first.
